// File: rtl/main_memory_bram_capture.sv
// main_memory_bram_capture: multi-channel circular BRAM capture with a pre/post-trigger window,
// replayed in chronological order over valid/ready through a 2-entry skid buffer.
module main_memory_bram_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         abort,
    input  logic [ADDR_WIDTH-1:0]        pretrig_len,
    input  logic                         samp_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] samp_data,
    input  logic                         trigger,
    input  logic                         rd_start,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_last,
    output logic                         busy,
    output logic                         done
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int W = NUM_CH*DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_N = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_N   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = '1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ} state_t;
    state_t state, nxt;

    logic [ADDR_WIDTH-1:0] wr_ptr, cnt, pt, start_addr, rd_ptr, xfer, rd_addr;
    logic [ADDR_WIDTH:0]   post_cnt, post_len, issued;
    logic [1:0]            fcnt, fill;
    logic                  inflight, capturing, we, arm_ok, trig_hit, start_rd, pop, space, issue;
    logic [W-1:0]          ram_q, f0, f1;

    assign capturing = state inside {S_PRE, S_WAIT, S_POST};
    assign arm_ok    = arm && (state == S_IDLE || state == S_DONE);
    assign we        = capturing && samp_valid && !abort;
    assign trig_hit  = state == S_WAIT && samp_valid && trigger;
    assign post_len  = DEPTH_N - {1'b0, pt};
    assign start_rd  = state == S_DONE && rd_start && !arm && !abort;
    assign pop       = rd_valid && rd_ready;
    assign fill      = fcnt - {1'b0, pop};
    // A new read may issue only if its data will still find a free slot one cycle later
    assign space     = (fcnt + {1'b0, inflight}) <= ({1'b0, pop} + 2'd1);
    assign issue     = start_rd || (state == S_READ && !abort && issued < DEPTH_N && space);
    assign rd_addr   = start_rd ? start_addr : rd_ptr;
    assign rd_valid  = fcnt != 2'd0;
    assign rd_data   = f0;
    assign rd_last   = rd_valid && xfer == LAST_A;
    assign busy      = capturing || state == S_READ;
    assign done      = state == S_DONE;

    always_comb begin
        nxt = state;
        if (abort) nxt = S_IDLE;
        else case (state)
            S_IDLE, S_DONE: if (arm) nxt = pretrig_len == '0 ? S_WAIT : S_PRE;
                            else if (state == S_DONE && rd_start) nxt = S_READ;
            S_PRE:  if (samp_valid && cnt + ONE_A == pt) nxt = S_WAIT;
            S_WAIT: if (trig_hit) nxt = post_len == ONE_N ? S_DONE : S_POST;
            S_POST: if (samp_valid && post_cnt + ONE_N == post_len) nxt = S_DONE;
            S_READ: if (pop && rd_last) nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            pt         <= '0;
            start_addr <= '0;
            post_cnt   <= '0;
            rd_ptr     <= '0;
            issued     <= '0;
            xfer       <= '0;
            inflight   <= 1'b0;
            fcnt       <= '0;
            f0         <= '0;
            f1         <= '0;
        end else begin
            if (arm_ok && !abort) begin
                wr_ptr <= '0;
                cnt    <= '0;
                pt     <= pretrig_len;
            end
            if (we) wr_ptr <= wr_ptr + ONE_A;
            if (we && state == S_PRE) cnt <= cnt + ONE_A;
            if (trig_hit && !abort) begin
                start_addr <= wr_ptr - pt;
                post_cnt   <= ONE_N;
            end else if (we && state == S_POST) post_cnt <= post_cnt + ONE_N;
            inflight <= issue;
            if (issue) begin
                rd_ptr <= rd_addr + ONE_A;
                issued <= start_rd ? ONE_N : issued + ONE_N;
            end
            if (start_rd) xfer <= '0;
            else if (pop) xfer <= xfer + ONE_A;
            fcnt <= abort ? 2'd0 : fcnt + {1'b0, inflight} - {1'b0, pop};
            if (inflight && fill == 2'd0) f0 <= ram_q;
            else if (pop) f0 <= f1;
            if (inflight && fill == 2'd1) f1 <= ram_q;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] q;
        always_ff @(posedge clk) begin
            if (we) mem[wr_ptr] <= samp_data[c*DATA_WIDTH +: DATA_WIDTH];
            if (issue) q <= mem[rd_addr];
        end
        assign ram_q[c*DATA_WIDTH +: DATA_WIDTH] = q;
    end
endmodule
